// File: rtl/seq_detect_pkg.sv
// Shared constants for the serial sequence detector.
// Holds the default pattern and length, the legal parameter limits and the
// overlap mode encoding used to interpret the overlap_en input.
package seq_detect_pkg;

  localparam int unsigned SeqLenDefault = 4;
  localparam logic [3:0]  SeqPatternDefault = 4'b1011;
  localparam int unsigned CntWDefault = 8;

  localparam int unsigned SeqLenMin = 2;
  localparam int unsigned SeqLenMax = 16;
  localparam int unsigned CntWMin = 1;
  localparam int unsigned CntWMax = 16;

  typedef enum logic {
    ModeNonOverlap = 1'b0,
    ModeOverlap    = 1'b1
  } overlap_mode_e;

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, loads 0
//   inc   - count one event this cycle
//   clr   - clear this cycle; with inc set in the same cycle the result is 1
//   cnt   - current count, sticks at all-ones
module seq_sat_cnt
  import seq_detect_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  if (CNT_W < CntWMin || CNT_W > CntWMax) begin : gen_bad_cnt_w
    $error("seq_sat_cnt: CNT_W out of range");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      // Clear first, then count the coincident event.
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_n.sv
// Serial pattern detector for a SEQ_LEN-bit pattern (MSB received first).
// Build option: define SEQ_DETECT_CNT_EN to include the saturating match counter;
// otherwise match_cnt is constant 0 and clear_cnt is ignored.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   inp_valid  - qualifies inp_bit
//   inp_bit    - serial data
//   overlap_en - 1: matches may share bits, 0: each match needs fresh bits
//   clear_cnt  - synchronous clear of match_cnt
//   seq_seen   - registered one-cycle pulse after the completing bit
//   match_cnt  - saturating number of matches
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int unsigned        SEQ_LEN     = SeqLenDefault,
  parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = SEQ_LEN'(SeqPatternDefault),
  parameter int unsigned        CNT_W       = CntWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inp_valid,
  input  logic             inp_bit,
  input  logic             overlap_en,
  input  logic             clear_cnt,
  output logic             seq_seen,
  output logic [CNT_W-1:0] match_cnt
);

  if (SEQ_LEN < SeqLenMin || SEQ_LEN > SeqLenMax) begin : gen_bad_seq_len
    $error("seq_detect_n: SEQ_LEN out of range");
  end
  if (CNT_W < CntWMin || CNT_W > CntWMax) begin : gen_bad_cnt_w
    $error("seq_detect_n: CNT_W out of range");
  end

  localparam int unsigned      FillW    = $clog2(SEQ_LEN + 1);
  localparam logic [FillW-1:0] FillMax  = FillW'(SEQ_LEN);
  localparam logic [FillW-1:0] FillLast = FillW'(SEQ_LEN - 1);

  logic [SEQ_LEN-1:0] hist_q, hist_d, hist_next;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               seen_q, seen_d;
  logic               match;

  assign hist_next = {hist_q[SEQ_LEN-2:0], inp_bit};
  // The fill guard keeps stale or reset-zero history bits from forming a match.
  assign match = inp_valid && (fill_q >= FillLast) && (hist_next == SEQ_PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    seen_d = match;
    if (inp_valid) begin
      hist_d = hist_next;
      if (match && (overlap_mode_e'(overlap_en) == ModeNonOverlap)) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      seen_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      seen_q <= seen_d;
    end
  end

  assign seq_seen = seen_q;

`ifdef SEQ_DETECT_CNT_EN
  seq_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (clear_cnt),
    .cnt  (match_cnt)
  );
`else
  logic unused_clear_cnt;
  assign unused_clear_cnt = clear_cnt;
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_n.sv
// Bench for seq_detect_n: three instances (default, all-zero pattern, 2-bit counter)
// share one stimulus stream and are compared every cycle against a model that keeps
// the list of valid bits received and the start of the current detection window.
module tb_seq_detect_n;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inp_valid = 1'b0;
  logic inp_bit = 1'b0;
  logic overlap_en = 1'b0;
  logic clear_cnt = 1'b0;
  logic [2:0] seen_v;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detect_n #(.SEQ_LEN(4), .SEQ_PATTERN(4'b1011), .CNT_W(8)) u_def (
    .clk(clk), .reset(reset), .inp_valid(inp_valid), .inp_bit(inp_bit),
    .overlap_en(overlap_en), .clear_cnt(clear_cnt), .seq_seen(seen_v[0]), .match_cnt(cnt0)
  );
  seq_detect_n #(.SEQ_LEN(4), .SEQ_PATTERN(4'b0000), .CNT_W(8)) u_zero (
    .clk(clk), .reset(reset), .inp_valid(inp_valid), .inp_bit(inp_bit),
    .overlap_en(overlap_en), .clear_cnt(clear_cnt), .seq_seen(seen_v[1]), .match_cnt(cnt1)
  );
  seq_detect_n #(.SEQ_LEN(4), .SEQ_PATTERN(4'b1011), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .inp_valid(inp_valid), .inp_bit(inp_bit),
    .overlap_en(overlap_en), .clear_cnt(clear_cnt), .seq_seen(seen_v[2]), .match_cnt(cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  bit         stream[$];
  int         start[3];
  int         mcnt[3];
  bit         mseen[3];
  logic [3:0] pat[3] = '{4'b1011, 4'b0000, 4'b1011};
  int         cmax[3] = '{255, 255, 3};

  function automatic bit tail_matches(int i);
    int n = stream.size();
    if (n - start[i] < 4) return 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (stream[n-4+k] != pat[i][3-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit v, input bit b, input bit ov, input bit clr,
                            input bit rst);
    if (rst) begin
      stream.delete();
      for (int i = 0; i < 3; i++) begin
        start[i] = 0;
        mcnt[i]  = 0;
        mseen[i] = 1'b0;
      end
      return;
    end
    if (v) stream.push_back(b);
    for (int i = 0; i < 3; i++) begin
      bit m = v && tail_matches(i);
      mseen[i] = m;
      if (CntEn) begin
        if (clr) mcnt[i] = m ? 1 : 0;
        else if (m && mcnt[i] < cmax[i]) mcnt[i]++;
      end
      if (m && !ov) start[i] = stream.size();
    end
  endtask

  int bit_idx = 0;
  int mask[3];

  task automatic compare_all();
    check("def_seen", 32'(seen_v[0]), 32'(mseen[0]));
    check("zero_seen", 32'(seen_v[1]), 32'(mseen[1]));
    check("small_seen", 32'(seen_v[2]), 32'(mseen[2]));
    check("def_cnt", 32'(cnt0), 32'(mcnt[0]));
    check("zero_cnt", 32'(cnt1), 32'(mcnt[1]));
    check("small_cnt", 32'(cnt2), 32'(mcnt[2]));
  endtask

  task automatic drive(input bit v, input bit b, input bit ov, input bit clr, input bit rst);
    inp_valid  = v;
    inp_bit    = b;
    overlap_en = ov;
    clear_cnt  = clr;
    reset      = rst;
    model_step(v, b, ov, clr, rst);
    @(posedge clk);
    #1;
    if (v && !rst) bit_idx++;
    for (int i = 0; i < 3; i++) begin
      if (seen_v[i] === 1'b1 && bit_idx < 32) mask[i] |= (1 << bit_idx);
    end
    compare_all();
  endtask

  task automatic reset_run();
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    bit_idx = 0;
    for (int i = 0; i < 3; i++) mask[i] = 0;
  endtask

  bit [6:0] s7 = 7'b1011011;

  initial begin
    // Overlapping stream 1,0,1,1,0,1,1
    reset_run();
    for (int k = 6; k >= 0; k--) drive(1, s7[k], 1, 0, 0);
    check("ovl_mask", 32'(mask[0]), 32'h90);
    check("ovl_cnt", 32'(cnt0), CntEn ? 32'd2 : 32'd0);

    // Same stream, non-overlapping
    reset_run();
    for (int k = 6; k >= 0; k--) drive(1, s7[k], 0, 0, 0);
    check("novl_mask", 32'(mask[0]), 32'h10);
    check("novl_cnt", 32'(cnt0), CntEn ? 32'd1 : 32'd0);

    // All-zero pattern right after reset
    reset_run();
    for (int k = 0; k < 4; k++) drive(1, 0, 1, 0, 0);
    check("zero_mask", 32'(mask[1]), 32'h10);
    check("zero_def_mask", 32'(mask[0]), 32'h0);

    // Gap in valid does not break the sequence
    reset_run();
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    check("gap_mask", 32'(mask[0]), 32'h10);

    // 2-bit counter saturation and clear-with-match
    reset_run();
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    check("sat_cnt_1", 32'(cnt2), CntEn ? 32'd1 : 32'd0);
    for (int m = 2; m <= 6; m++) begin
      drive(1, 0, 1, 0, 0);
      drive(1, 1, 1, 0, 0);
      drive(1, 1, 1, 0, 0);
      check($sformatf("sat_cnt_%0d", m), 32'(cnt2), CntEn ? 32'(m > 3 ? 3 : m) : 32'd0);
    end
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 0);
    check("clr_match_small", 32'(cnt2), CntEn ? 32'd1 : 32'd0);
    check("clr_match_def", 32'(cnt0), CntEn ? 32'd1 : 32'd0);
    drive(0, 0, 1, 1, 0);
    check("clr_only", 32'(cnt0), 32'd0);

    // Reset discards a partial sequence
    reset_run();
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 1);
    check("rst_seen", 32'(seen_v), 32'd0);
    check("rst_cnt", 32'(cnt0) | 32'(cnt2), 32'd0);
    drive(1, 1, 1, 0, 0);
    check("rst_nopulse", 32'(seen_v[0]), 32'd0);

    // Randomized traffic
    begin
      bit ov = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 49) == 0) ov = ~ov;
        drive($urandom_range(0, 9) < 7, 1'($urandom), ov, $urandom_range(0, 39) == 0,
              $urandom_range(0, 299) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
